// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR phase controller.
//   cdr_state_e : loop FSM state (ACQ / LOCK / FREEZE)
//   PTR_W       : phase pointer width (32 phases)
//   PHASE_W     : thermometer phase code width
//   ptr2therm() : pointer -> 16-bit thermometer phase code
package cdr_pkg;

  localparam int PTR_W   = 5;
  localparam int PHASE_W = 16;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCK   = 2'd1,
    FREEZE = 2'd2
  } cdr_state_e;

  // 0 -> all zero; 1..16 -> lower p bits set; 17..31 -> ones shifted out from
  // the bottom, so the code walks a full circle of 32 distinct patterns.
  function automatic logic [PHASE_W-1:0] ptr2therm(input logic [PTR_W-1:0] p);
    logic [31:0] t;
    if (p <= 5'd16) t = (32'd1 << p) - 32'd1;
    else            t = 32'h0000_FFFF << (p - 5'd16);
    return t[PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/cdr_vote_filter.sv
// Early/late vote accumulator with symmetric threshold.
//   clk, rst_gen : clock, synchronous active-high reset
//   clr          : clear accumulator (pointer load)
//   en           : accept votes this cycle (low while frozen/loading)
//   vote_valid, early, late : phase-detector vote
//   up, dn       : combinational strobes, high on the edge the threshold is hit
module cdr_vote_filter
  #(parameter int VOTE_TH = 8)
  (
  input  logic clk,
  input  logic rst_gen,
  input  logic clr,
  input  logic en,
  input  logic vote_valid,
  input  logic early,
  input  logic late,
  output logic up,
  output logic dn
  );

  localparam logic signed [4:0] TH_P = 5'(VOTE_TH);
  localparam logic signed [4:0] TH_N = -TH_P;

  logic signed [4:0] acc_q, acc_d, acc_next, delta;

  always_comb begin
    delta = 5'sd0;
    if (vote_valid && early && !late)      delta = 5'sd1;
    else if (vote_valid && late && !early) delta = -5'sd1;
    acc_next = acc_q + delta;
    up = en && (acc_next == TH_P);
    dn = en && (acc_next == TH_N);
    if (clr)          acc_d = 5'sd0;
    else if (!en)     acc_d = acc_q;
    else if (up | dn) acc_d = 5'sd0;
    else              acc_d = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst_gen) acc_q <= 5'sd0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/cdr_phase_ctrl.sv
// CDR phase pointer controller: filters early/late votes into pointer steps,
// tracks lock from the step direction pattern, and drives a thermometer code.
//   clk, rst_gen          : clock, synchronous active-high reset
//   early, late, vote_valid : phase-detector votes
//   hold                  : freeze the loop
//   load_en, load_idx     : force the pointer
//   phase_idx, phase_out  : registered pointer and thermometer code
//   step_up, step_dn      : one-cycle step pulses
//   locked                : high in LOCK
module cdr_phase_ctrl
  import cdr_pkg::*;
  #(parameter int VOTE_TH = 8,
    parameter int LOCK_N  = 4)
  (
  input  logic               clk,
  input  logic               rst_gen,
  input  logic               early,
  input  logic               late,
  input  logic               vote_valid,
  input  logic               hold,
  input  logic               load_en,
  input  logic [PTR_W-1:0]   load_idx,
  output logic [PTR_W-1:0]   phase_idx,
  output logic [PHASE_W-1:0] phase_out,
  output logic               step_up,
  output logic               step_dn,
  output logic               locked
  );

  cdr_state_e state_q, state_d, prev_q, prev_d, cur;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [3:0] alt_cnt_q, alt_cnt_d, alt_inc;
  logic [1:0] same_cnt_q, same_cnt_d;
  logic last_up_q, last_up_d, have_dir_q, have_dir_d;
  logic locked_q, locked_d, step_up_q, step_up_d, step_dn_q, step_dn_d;
  logic f_up, f_dn, alt;

  cdr_vote_filter #(.VOTE_TH(VOTE_TH)) u_filt (
    .clk(clk), .rst_gen(rst_gen), .clr(load_en), .en(!load_en && !hold),
    .vote_valid(vote_valid), .early(early), .late(late), .up(f_up), .dn(f_dn)
  );

  always_comb begin
    state_d = state_q; prev_d = prev_q; ptr_d = ptr_q;
    alt_cnt_d = alt_cnt_q; same_cnt_d = same_cnt_q;
    last_up_d = last_up_q; have_dir_d = have_dir_q; locked_d = locked_q;
    step_up_d = 1'b0; step_dn_d = 1'b0;
    // Leaving FREEZE behaves as the state held before entry.
    cur = (state_q == FREEZE) ? prev_q : state_q;
    alt = have_dir_q && (f_up != last_up_q);
    alt_inc = alt_cnt_q + 4'd1;
    if (load_en) begin
      ptr_d = load_idx; alt_cnt_d = '0; same_cnt_d = '0;
      have_dir_d = 1'b0; state_d = ACQ; locked_d = 1'b0;
    end else if (hold) begin
      if (state_q != FREEZE) begin
        prev_d  = state_q;
        state_d = FREEZE;
      end
    end else begin
      state_d = cur;
      if (f_up || f_dn) begin
        step_up_d = f_up; step_dn_d = f_dn;
        ptr_d = f_up ? ptr_q + 5'd1 : ptr_q - 5'd1;
        have_dir_d = 1'b1; last_up_d = f_up;
        if (cur == LOCK) begin
          if (alt)                   same_cnt_d = '0;
          else if (same_cnt_q == 2'd1) begin
            state_d = ACQ; locked_d = 1'b0; alt_cnt_d = '0; same_cnt_d = '0;
          end else                   same_cnt_d = same_cnt_q + 2'd1;
        end else begin
          if (!alt)                  alt_cnt_d = '0;
          else if (alt_inc == 4'(LOCK_N)) begin
            state_d = LOCK; locked_d = 1'b1; alt_cnt_d = '0; same_cnt_d = '0;
          end else                   alt_cnt_d = alt_inc;
        end
      end
    end
    phase_d = ptr2therm(ptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst_gen) begin
      state_q <= ACQ; prev_q <= ACQ; ptr_q <= '0; phase_q <= '0;
      alt_cnt_q <= '0; same_cnt_q <= '0; last_up_q <= 1'b0; have_dir_q <= 1'b0;
      locked_q <= 1'b0; step_up_q <= 1'b0; step_dn_q <= 1'b0;
    end else begin
      state_q <= state_d; prev_q <= prev_d; ptr_q <= ptr_d; phase_q <= phase_d;
      alt_cnt_q <= alt_cnt_d; same_cnt_q <= same_cnt_d;
      last_up_q <= last_up_d; have_dir_q <= have_dir_d;
      locked_q <= locked_d; step_up_q <= step_up_d; step_dn_q <= step_dn_d;
    end
  end

  assign phase_idx = ptr_q;
  assign phase_out = phase_q;
  assign step_up   = step_up_q;
  assign step_dn   = step_dn_q;
  assign locked    = locked_q;

endmodule

// File: doc/cdr_phase_ctrl.md
CDR_PHASE_CTRL -- requirements
Module: cdr_phase_ctrl

Interface
REQ-001 Parameter VOTE_TH, default 8, votes of one sign needed to move the phase pointer one step (legal 2..15).
REQ-002 Parameter LOCK_N, default 4, consecutive alternating-direction steps needed to declare lock (legal 2..15).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_gen  input  1  synchronous, active-high reset.
REQ-005 early  input  1  phase-detector vote: sampling early, advance phase; qualified by vote_valid.
REQ-006 late  input  1  phase-detector vote: sampling late, retard phase; qualified by vote_valid.
REQ-007 vote_valid  input  1  early/late valid this cycle.
REQ-008 hold  input  1  freeze the loop.
REQ-009 load_en  input  1  one-cycle strobe, force pointer to load_idx.
REQ-010 load_idx  input  5  forced pointer value.
REQ-011 phase_idx  output  5  registered phase pointer 0..31.
REQ-012 phase_out  output  16  registered thermometer phase code of phase_idx.
REQ-013 step_up / step_dn  output  1 each  one-cycle pulse on the edge the pointer increments / decrements.
REQ-014 locked  output  1  registered, high in state LOCK only.

Function
REQ-015 Code map: p=0 gives 0x0000; p=k (1..16) gives lower k bits set; p=16+k (k=1..15) gives 0xFFFF shifted left k, truncated to 16 bits (p=17 gives 0xFFFE, p=31 gives 0x8000).
REQ-016 Vote delta: +1 if vote_valid&early&!late; -1 if vote_valid&late&!early; 0 otherwise.
REQ-017 Accumulator: signed 5-bit, acc_next=acc+delta.
REQ-018 acc_next==+VOTE_TH: acc<=0, ptr<=ptr+1 mod 32, step_up<=1, all on the same edge.
REQ-019 acc_next==-VOTE_TH: acc<=0, ptr<=ptr-1 mod 32, step_dn<=1.
REQ-020 Otherwise acc<=acc_next; ptr unchanged; step pulses 0.
REQ-021 Latency: a threshold-reaching vote sampled at edge n changes phase_idx and phase_out, and pulses step_*, after edge n, together.
REQ-022 Wrap: 31+1 gives 0 (0x0000); 0-1 gives 31 (0x8000).
REQ-023 FSM states: ACQ, LOCK, FREEZE.
REQ-024 ACQ: alt_cnt counts consecutive steps whose direction differs from the previous step (first step after reset/load has no predecessor, alt_cnt=0); same-direction step gives alt_cnt<=0.
REQ-025 ACQ to LOCK when alt_cnt reaches LOCK_N; locked<=1 on that edge.
REQ-026 LOCK: same-direction step increments same_cnt; alternating step clears it.
REQ-027 LOCK to ACQ when same_cnt reaches 2: locked<=0, alt_cnt<=0, same_cnt<=0.
REQ-028 hold=1: enter FREEZE from ACQ/LOCK; votes ignored; acc, ptr, counters retained; locked keeps its prior value.
REQ-029 hold=0: FREEZE returns to the state held before entry on the next edge.
REQ-030 load_en=1: ptr<=load_idx, phase_out<=map(load_idx), acc/alt_cnt/same_cnt<=0, state ACQ, locked<=0, no step pulse.
REQ-031 Priority: rst_gen > load_en > hold > votes. A vote coincident with load_en or hold is discarded.

Reset
REQ-032 rst_gen at an edge: phase_idx=0, phase_out=0x0000, step_up=step_dn=0, locked=0, acc=0, alt_cnt=same_cnt=0, state ACQ.
REQ-033 Reset mid-operation, including in FREEZE or LOCK, discards all history, with no residual step pulse on the following cycle.

Structure
REQ-034 Shared package cdr_pkg holds the FSM state enum, PTR_W=5, PHASE_W=16 and the pointer-to-thermometer map function.
REQ-035 One sub-module, cdr_vote_filter (accumulator plus threshold compare, emits up/down strobes); the FSM, counters and output registers stay in the top.

Verification
REQ-036 Reset, then 8 early votes -> after 8th edge phase_idx=1, phase_out=0x0001, single step_up pulse, locked=0.
REQ-037 load_idx=31, then 8 early -> phase_idx=0, phase_out=0x0000; then 8 late -> phase_idx=31, phase_out=0x8000.
REQ-038 20 cycles of early&late both high with vote_valid -> no step, phase_idx unchanged; then 7 early -> still no step.
REQ-039 Repeat 8 early/8 late until 5 steps (up,dn,up,dn,up) -> locked=1 on 5th step edge; then 16 early -> locked=0 on 2nd subsequent step_up.
REQ-040 5 early, then hold=1 for 10 cycles with early asserted, then release, then 3 early -> no step during hold; step_up on 3rd post-release vote.
REQ-041 In LOCK assert rst_gen for one cycle -> next cycle phase_out=0x0000, locked=0, no step pulse; load_en with hold and early together -> load wins, state ACQ.
